// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad column scanner with press/release debounce
//
// Purpose: drives one keypad column at a time, samples the row lines at the
// end of each column's dwell, debounces a detected key and reports it.
//
// Ports:
//   clock   in   1  system clock, rising edge
//   reset   in   1  synchronous, active-high
//   row     in   4  row sense lines, active-high, already synchronised
//   col     out  4  one-hot active-high column drive
//   keycode out  4  {row index, column index} of the last accepted key
//   newkey  out  1  one-cycle pulse per accepted press
//   keydown out  1  high while the accepted key is held
`timescale 1ns/1ps

module keypad_scan #(
  parameter int SCAN_CYCLES = 4,
  parameter int DEBOUNCE    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] keycode,
  output logic       newkey,
  output logic       keydown
);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(SCAN_CYCLES - 1);
  localparam logic [7:0] DEB_COUNT  = 8'(DEBOUNCE);

  state_t     state_q,   state_d;
  logic [3:0] col_q,     col_d;
  logic [7:0] dwell_q,   dwell_d;
  logic [7:0] match_q,   match_d;
  logic [3:0] cand_q,    cand_d;
  logic [3:0] keycode_q, keycode_d;
  logic       newkey_q,  newkey_d;
  logic       keydown_q, keydown_d;

  logic       cand_bit;
  logic [3:0] col_next;
  logic [7:0] match_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // row[0] has the highest priority when several rows are active
  function automatic logic [1:0] low_row(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    if (r[3]) idx = 2'd3;
    if (r[2]) idx = 2'd2;
    if (r[1]) idx = 2'd1;
    if (r[0]) idx = 2'd0;
    return idx;
  endfunction

  function automatic logic [1:0] col_idx(input logic [3:0] c);
    logic [1:0] idx;
    case (c)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // The column is frozen outside SCAN, so the candidate's row line alone
  // tells whether the candidate key is still down.
  assign cand_bit  = row[cand_q[3:2]];
  assign col_next  = {col_q[2:0], col_q[3]};
  assign match_inc = sat_inc(match_q);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    dwell_d   = dwell_q;
    match_d   = match_q;
    cand_d    = cand_q;
    keycode_d = keycode_q;
    newkey_d  = 1'b0;
    keydown_d = keydown_q;

    case (state_q)
      ST_SCAN: begin
        keydown_d = 1'b0;
        if (dwell_q >= DWELL_LAST) begin
          dwell_d = 8'd0;
          if (row == 4'b0000) begin
            col_d = col_next;
          end else begin
            cand_d  = {low_row(row), col_idx(col_q)};
            match_d = 8'd0;
            state_d = ST_DEBOUNCE;
          end
        end else begin
          dwell_d = sat_inc(dwell_q);
        end
      end

      ST_DEBOUNCE: begin
        if (!cand_bit) begin
          state_d = ST_SCAN;
          col_d   = col_next;
          dwell_d = 8'd0;
        end else if (match_q >= DEB_COUNT) begin
          // accept one edge after the count is reached so the pulse lands
          // DEBOUNCE+1 edges after the detecting sample
          keycode_d = cand_q;
          newkey_d  = 1'b1;
          keydown_d = 1'b1;
          state_d   = ST_HELD;
        end else begin
          match_d = match_inc;
        end
      end

      ST_HELD: begin
        keydown_d = 1'b1;
        if (!cand_bit) begin
          match_d = 8'd0;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (cand_bit) begin
          match_d = 8'd0;
          state_d = ST_HELD;
        end else if (match_inc >= DEB_COUNT) begin
          keydown_d = 1'b0;
          state_d   = ST_SCAN;
          col_d     = col_next;
          dwell_d   = 8'd0;
        end else begin
          match_d = match_inc;
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_SCAN;
      col_q     <= 4'b0001;
      dwell_q   <= 8'd0;
      match_q   <= 8'd0;
      cand_q    <= 4'd0;
      keycode_q <= 4'd0;
      newkey_q  <= 1'b0;
      keydown_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      match_q   <= match_d;
      cand_q    <= cand_d;
      keycode_q <= keycode_d;
      newkey_q  <= newkey_d;
      keydown_q <= keydown_d;
    end
  end

  assign col     = col_q;
  assign keycode = keycode_q;
  assign newkey  = newkey_q;
  assign keydown = keydown_q;

endmodule
